// File: rtl/crtc_pkg.sv
// Shared definitions for the 6845-style CRT timing generator: register
// indices, reset defaults, counter widths and the programmed-register bundle.
package crtc_pkg;

  localparam int HC_W = 8;
  localparam int RC_W = 5;
  localparam int VC_W = 7;
  localparam int AC_W = 5;
  localparam int SC_W = 4;
  localparam int AR_W = 5;

  localparam logic [AR_W-1:0] R_HTOTAL   = 5'd0;
  localparam logic [AR_W-1:0] R_HDISP    = 5'd1;
  localparam logic [AR_W-1:0] R_HSYNCPOS = 5'd2;
  localparam logic [AR_W-1:0] R_SYNCW    = 5'd3;
  localparam logic [AR_W-1:0] R_VTOTAL   = 5'd4;
  localparam logic [AR_W-1:0] R_VADJ     = 5'd5;
  localparam logic [AR_W-1:0] R_VDISP    = 5'd6;
  localparam logic [AR_W-1:0] R_VSYNCPOS = 5'd7;
  localparam logic [AR_W-1:0] R_MAXRAS   = 5'd9;
  localparam logic [AR_W-1:0] R_STARTH   = 5'd12;
  localparam logic [AR_W-1:0] R_STARTL   = 5'd13;

  typedef struct packed {
    logic [HC_W-1:0] htotal;
    logic [HC_W-1:0] hdisp;
    logic [HC_W-1:0] hsyncpos;
    logic [7:0]      syncw;
    logic [VC_W-1:0] vtotal;
    logic [AC_W-1:0] vadj;
    logic [VC_W-1:0] vdisp;
    logic [VC_W-1:0] vsyncpos;
    logic [RC_W-1:0] maxras;
    logic [5:0]      starth;
    logic [7:0]      startl;
  } crtc_regs_t;

  localparam logic [HC_W-1:0] DEF_HTOTAL   = 8'd63;
  localparam logic [HC_W-1:0] DEF_HDISP    = 8'd32;
  localparam logic [HC_W-1:0] DEF_HSYNCPOS = 8'd40;
  localparam logic [7:0]      DEF_SYNCW    = 8'h35;
  localparam logic [VC_W-1:0] DEF_VTOTAL   = 7'd38;
  localparam logic [AC_W-1:0] DEF_VADJ     = 5'd6;
  localparam logic [VC_W-1:0] DEF_VDISP    = 7'd32;
  localparam logic [VC_W-1:0] DEF_VSYNCPOS = 7'd35;
  localparam logic [RC_W-1:0] DEF_MAXRAS   = 5'd7;

  localparam crtc_regs_t REGS_DEFAULT = '{
    htotal:   DEF_HTOTAL,
    hdisp:    DEF_HDISP,
    hsyncpos: DEF_HSYNCPOS,
    syncw:    DEF_SYNCW,
    vtotal:   DEF_VTOTAL,
    vadj:     DEF_VADJ,
    vdisp:    DEF_VDISP,
    vsyncpos: DEF_VSYNCPOS,
    maxras:   DEF_MAXRAS,
    starth:   6'd0,
    startl:   8'd0
  };

  // Units still to run after the first sync unit; width code 0 means 16,
  // which the 4-bit wrap of w-1 gives for free.
  function automatic logic [SC_W-1:0] sync_left(input logic [SC_W-1:0] w);
    return w - SC_W'(1);
  endfunction

endpackage

// File: rtl/crtc_if.sv
// CPU access port of the CRT controller: address/data register pair
// with a combinational read-back path.
interface crtc_if;
  logic       cs;
  logic       rs;
  logic       wr;
  logic [7:0] di;
  logic [7:0] dout;

  modport master (output cs, output rs, output wr, output di, input dout);
  modport slave  (input cs, input rs, input wr, input di, output dout);
endinterface

// File: rtl/crtc_regs.sv
// Address/data register file with reset defaults; only the start address
// registers are readable.
module crtc_regs
  import crtc_pkg::*;
(
  input  logic       clock,
  input  logic       nreset,
  crtc_if.slave      bus,
  output crtc_regs_t o_regs
);

  logic [AR_W-1:0] r_addr;
  crtc_regs_t      r_regs;
  logic            w_wr_addr;
  logic            w_wr_data;

  assign w_wr_addr = bus.cs & bus.wr & ~bus.rs;
  assign w_wr_data = bus.cs & bus.wr & bus.rs;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_addr <= '0;
      r_regs <= REGS_DEFAULT;
    end else begin
      if (w_wr_addr) begin
        r_addr <= bus.di[AR_W-1:0];
      end
      if (w_wr_data) begin
        case (r_addr)
          R_HTOTAL:   r_regs.htotal   <= bus.di;
          R_HDISP:    r_regs.hdisp    <= bus.di;
          R_HSYNCPOS: r_regs.hsyncpos <= bus.di;
          R_SYNCW:    r_regs.syncw    <= bus.di;
          R_VTOTAL:   r_regs.vtotal   <= bus.di[VC_W-1:0];
          R_VADJ:     r_regs.vadj     <= bus.di[AC_W-1:0];
          R_VDISP:    r_regs.vdisp    <= bus.di[VC_W-1:0];
          R_VSYNCPOS: r_regs.vsyncpos <= bus.di[VC_W-1:0];
          R_MAXRAS:   r_regs.maxras   <= bus.di[RC_W-1:0];
          R_STARTH:   r_regs.starth   <= bus.di[5:0];
          R_STARTL:   r_regs.startl   <= bus.di;
          default:    ;
        endcase
      end
    end
  end

  assign bus.dout = (r_addr == R_STARTH) ? {2'b00, r_regs.starth} :
                    (r_addr == R_STARTL) ? r_regs.startl : 8'h00;

  assign o_regs = r_regs;

endmodule

// File: rtl/crtc.sv
// Character-based CRT timing generator: horizontal/vertical counters, sync
// generation and registered video-timing outputs, advanced on the char enable.
module crtc
  import crtc_pkg::*;
#(
  parameter int MAW = 14,
  parameter int RAW = 5
) (
  input  logic           clock,
  input  logic           nreset,
  input  logic           i_ce,
  crtc_if.slave          bus,
  output logic [MAW-1:0] o_ma,
  output logic [RAW-1:0] o_ra,
  output logic           o_de,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_frame
);

  crtc_regs_t w_regs;

  crtc_regs u_regs (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus),
    .o_regs (w_regs)
  );

  logic [HC_W-1:0] r_hc;
  logic [RC_W-1:0] r_rc;
  logic [VC_W-1:0] r_vc;
  logic [AC_W-1:0] r_ac;
  logic [MAW-1:0]  r_mrow;
  logic            r_inadj;
  logic [SC_W-1:0] r_hsc;
  logic [SC_W-1:0] r_vsc;
  logic            r_hs_act;
  logic            r_vs_act;

  logic            w_line_end;
  logic            w_frame_end;
  logic [RC_W-1:0] w_rc_next;
  logic [VC_W-1:0] w_vc_next;
  logic [AC_W-1:0] w_ac_next;
  logic [MAW-1:0]  w_mrow_next;
  logic            w_inadj_next;
  logic [MAW-1:0]  w_start;
  logic            w_hs_start;
  logic            w_hsync;
  logic            w_vs_start;
  logic            w_vsync;
  logic [SC_W-1:0] w_vsc_cur;

  // A reprogrammed R0 below hc is caught by the 8-bit wrap, which also ends the line.
  assign w_line_end = (r_hc == w_regs.htotal) || (r_hc == 8'hFF);
  assign w_start    = MAW'({w_regs.starth, w_regs.startl});

  always_comb begin
    w_rc_next    = r_rc;
    w_vc_next    = r_vc;
    w_ac_next    = r_ac;
    w_mrow_next  = r_mrow;
    w_inadj_next = r_inadj;
    w_frame_end  = 1'b0;
    if (w_line_end) begin
      if (r_inadj) begin
        w_ac_next = r_ac + 5'd1;
        if (r_ac == w_regs.vadj - 5'd1) w_frame_end = 1'b1;
      end else if (r_rc == w_regs.maxras) begin
        w_rc_next   = '0;
        w_mrow_next = r_mrow + MAW'(w_regs.hdisp);
        if (r_vc == w_regs.vtotal) begin
          if (w_regs.vadj == '0) begin
            w_frame_end = 1'b1;
          end else begin
            w_inadj_next = 1'b1;
            w_ac_next    = '0;
          end
        end else begin
          w_vc_next = r_vc + 7'd1;
        end
      end else begin
        w_rc_next = r_rc + 5'd1;
      end
      if (w_frame_end) begin
        w_vc_next    = '0;
        w_rc_next    = '0;
        w_ac_next    = '0;
        w_inadj_next = 1'b0;
        w_mrow_next  = w_start;
      end
    end
  end

  assign w_hs_start = (r_hc == w_regs.hsyncpos);
  assign w_hsync    = w_hs_start | r_hs_act;
  assign w_vs_start = (r_hc == '0) && (r_vc == w_regs.vsyncpos) && (r_rc == '0) && !r_vs_act;
  assign w_vsync    = w_vs_start | r_vs_act;
  assign w_vsc_cur  = w_vs_start ? sync_left(w_regs.syncw[7:4]) : r_vsc;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_hc    <= '0;
      r_rc    <= '0;
      r_vc    <= '0;
      r_ac    <= '0;
      r_mrow  <= '0;
      r_inadj <= 1'b0;
    end else if (i_ce) begin
      r_hc    <= w_line_end ? '0 : r_hc + 8'd1;
      r_rc    <= w_rc_next;
      r_vc    <= w_vc_next;
      r_ac    <= w_ac_next;
      r_mrow  <= w_mrow_next;
      r_inadj <= w_inadj_next;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_hsc    <= '0;
      r_vsc    <= '0;
      r_hs_act <= 1'b0;
      r_vs_act <= 1'b0;
    end else if (i_ce) begin
      if (w_hs_start) begin
        r_hsc    <= sync_left(w_regs.syncw[3:0]);
        r_hs_act <= (w_regs.syncw[3:0] != 4'd1);
      end else if (r_hs_act) begin
        r_hsc    <= r_hsc - 4'd1;
        r_hs_act <= (r_hsc != 4'd1);
      end
      // Vertical sync counts whole lines; the remaining count drops at each line end.
      r_vs_act <= w_vsync && !(w_line_end && (w_vsc_cur == '0));
      r_vsc    <= w_line_end ? w_vsc_cur - 4'd1 : w_vsc_cur;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      o_ma    <= '0;
      o_ra    <= '0;
      o_de    <= 1'b0;
      o_hsync <= 1'b0;
      o_vsync <= 1'b0;
      o_frame <= 1'b0;
    end else if (i_ce) begin
      o_ma    <= r_mrow + MAW'(r_hc);
      o_ra    <= RAW'(r_inadj ? r_ac : r_rc);
      o_de    <= (r_hc < w_regs.hdisp) && (r_vc < w_regs.vdisp) && !r_inadj;
      o_hsync <= w_hsync;
      o_vsync <= w_vsync;
      o_frame <= (r_hc == '0) && (r_vc == '0) && (r_rc == '0) && !r_inadj;
    end
  end

endmodule

// File: tb/tb_crtc.sv
// Directed bench for crtc: default timing, programmed geometry, start address,
// adjust region, zero sync widths, shrinking R0 and mid-frame reset.
module tb_crtc;
  import crtc_pkg::*;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        ce = 1'b0;
  logic [13:0] ma;
  logic [4:0]  ra;
  logic        de, hsync, vsync, frame;

  crtc_if bus();

  crtc #(.MAW(14), .RAW(5)) dut (
    .clock   (clock),
    .nreset  (nreset),
    .i_ce    (ce),
    .bus     (bus),
    .o_ma    (ma),
    .o_ra    (ra),
    .o_de    (de),
    .o_hsync (hsync),
    .o_vsync (vsync),
    .o_frame (frame)
  );

  always #5 clock = ~clock;

  int   vectors = 0;
  int   miscompares = 0;
  int   tk = 0;
  int   tk0 = 0;
  logic hs_prev = 1'b0;
  int   rises[$];
  int   ls_ma[$];
  int   ls_ra[$];
  int   ls_de[$];
  int   m_t, m_de, m_hs, m_vs, m_vs_first;
  int   found, n0, n32, late;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    tk++;
    if (hsync && !hs_prev) rises.push_back(tk);
    hs_prev = hsync;
  endtask

  task automatic wr_addr(input logic [4:0] a);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.rs = 1'b0; bus.di = {3'b000, a};
    tick();
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [7:0] v);
    wr_addr(a);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.rs = 1'b1; bus.di = v;
    tick();
    bus.cs = 1'b0; bus.wr = 1'b0; bus.rs = 1'b0;
  endtask

  task automatic wait_frame(input int limit, output int ok);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!frame && n < limit);
    ok = frame ? 1 : 0;
  endtask

  // Observe one frame starting at the current frame pulse, L ce per line.
  task automatic measure(input int L, input int limit);
    int line_de = 0;
    m_t = 0; m_de = 0; m_hs = 0; m_vs = 0; m_vs_first = -1;
    ls_ma.delete(); ls_ra.delete(); ls_de.delete();
    do begin
      if (m_t % L == 0) begin
        ls_ma.push_back(int'(ma));
        ls_ra.push_back(int'(ra));
        line_de = 0;
      end
      if (de) begin m_de++; line_de++; end
      if (hsync) m_hs++;
      if (vsync) begin
        m_vs++;
        if (m_vs_first < 0) m_vs_first = m_t;
      end
      if (m_t % L == L - 1) ls_de.push_back(line_de);
      tick();
      m_t++;
    end while (!frame && m_t < limit);
  endtask

  function automatic int rise_at(input int i);
    return (i >= 0 && i < rises.size()) ? rises[i] : -1;
  endfunction
  function automatic int ra_at(input int i);
    return (i >= 0 && i < ls_ra.size()) ? ls_ra[i] : -1;
  endfunction
  function automatic int ma_at(input int i);
    return (i >= 0 && i < ls_ma.size()) ? ls_ma[i] : -1;
  endfunction

  initial begin
    bus.cs = 1'b0; bus.rs = 1'b0; bus.wr = 1'b0; bus.di = 8'h00;
    ce = 1'b1;
    nreset = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'({ma, ra, de, hsync, vsync, frame}), 32'h0);
    check("reset_do", 32'(bus.dout), 32'h0);

    // Default programming, ce every clock
    @(negedge clock);
    rises.delete();
    tk0 = tk;
    nreset = 1'b1;
    tick();
    check("first_frame", 32'(frame), 32'd1);
    check("first_ma", 32'(ma), 32'd0);
    check("first_de", 32'(de), 32'd1);
    measure(64, 30000);
    check("def_frame_period", m_t, 20352);
    check("def_hsync_start", rise_at(0) - tk0, 41);
    check("def_line_period", rise_at(1) - rise_at(0), 64);
    check("def_hsync_total", m_hs, 318 * 5);
    check("def_de_total", m_de, 256 * 32);
    n32 = 0; late = 0;
    for (int i = 0; i < ls_de.size(); i++) begin
      if (i < 256 && ls_de[i] == 32) n32++;
      if (i >= 256) late += ls_de[i];
    end
    check("def_de_lines32", n32, 256);
    check("def_de_late", late, 0);
    check("def_vsync_first", m_vs_first, 280 * 64);
    check("def_vsync_total", m_vs, 3 * 64);
    check("def_ma_line8", ma_at(8), 32);
    check("def_ra_line3", ra_at(3), 3);
    for (int j = 0; j < 6; j++) check("def_ra_adjust", ra_at(312 + j), j);

    // Small geometry, zero sync widths, start address 0x0180
    wr_reg(R_HTOTAL, 8'd31);
    wr_reg(R_HDISP, 8'd10);
    wr_reg(R_HSYNCPOS, 8'd8);
    wr_reg(R_SYNCW, 8'h00);
    wr_reg(R_VTOTAL, 8'd9);
    wr_reg(R_VADJ, 8'd3);
    wr_reg(R_VDISP, 8'd5);
    wr_reg(R_VSYNCPOS, 8'd2);
    wr_reg(R_MAXRAS, 8'd1);
    wr_reg(R_STARTH, 8'h01);
    wr_reg(R_STARTL, 8'h80);
    check("read_r13", 32'(bus.dout), 32'h80);
    wait_frame(4000, found);
    check("wait_frame_small", found, 1);
    check("start_ma", 32'(ma), 32'h180);
    measure(32, 2000);
    check("small_frame_period", m_t, 23 * 32);
    check("small_de_total", m_de, 10 * 10);
    check("hsync0_total", m_hs, 23 * 16);
    check("vsync0_first", m_vs_first, 4 * 32);
    check("vsync0_total", m_vs, 16 * 32);
    check("small_ma_row1", ma_at(2), 32'h18A);
    check("small_ra_line1", ra_at(1), 1);
    for (int j = 0; j < 3; j++) check("small_ra_adjust", ra_at(20 + j), j);
    tick();
    check("frame_single", 32'(frame), 32'd0);

    // No adjust lines
    wr_reg(R_VADJ, 8'd0);
    wait_frame(2000, found);
    check("wait_frame_noadj", found, 1);
    measure(32, 2000);
    check("noadj_frame_period", m_t, 20 * 32);
    check("noadj_ra_line19", ra_at(19), 1);

    // Shrink R0 below a running hc
    wr_reg(R_HTOTAL, 8'd63);
    check("read_other", 32'(bus.dout), 32'h0);
    wait_frame(2000, found);
    check("wait_frame_shrink", found, 1);
    repeat (49) tick();
    n0 = rises.size();
    bus.cs = 1'b1; bus.rs = 1'b1; bus.wr = 1'b1; bus.di = 8'd20;
    tick();
    bus.cs = 1'b0; bus.wr = 1'b0; bus.rs = 1'b0;
    repeat (260) tick();
    check("shrink_wrap_line", rise_at(n0) - rise_at(n0 - 1), 256);
    check("shrink_line1", rise_at(n0 + 1) - rise_at(n0), 21);
    check("shrink_line2", rise_at(n0 + 2) - rise_at(n0 + 1), 21);

    // Mid-frame reset
    wr_addr(R_STARTH);
    check("read_r12", 32'(bus.dout), 32'h01);
    @(posedge clock);
    #3;
    nreset = 1'b0;
    #1;
    check("midreset_outputs", 32'({ma, ra, de, hsync, vsync, frame}), 32'h0);
    check("midreset_do", 32'(bus.dout), 32'h0);
    repeat (2) tick();
    @(negedge clock);
    rises.delete();
    tk0 = tk;
    nreset = 1'b1;
    tick();
    check("rst_first_frame", 32'(frame), 32'd1);
    repeat (110) tick();
    check("rst_hsync_start", rise_at(0) - tk0, 41);
    check("rst_line_period", rise_at(1) - rise_at(0), 64);
    wr_addr(R_STARTH);
    check("rst_r12_default", 32'(bus.dout), 32'h0);
    wr_addr(R_STARTL);
    check("rst_r13_default", 32'(bus.dout), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crtc.md
# crtc

Character-based CRT timing generator, modelled on the 6845 register set. It produces the memory address, raster address, display enable and active-high composite sync pair that the video fetch/shift logic turns into the `ice`/`isync`/`irgb` stream consumed by the scandoubler. It is programmed by the CPU through an address-register/data-register pair and runs from a character-clock enable.

## Interface
- `MAW`, 14: memory address output width.
- `RAW`, 5: raster address output width.
- `clock` in 1: system clock, the only clock.
- `nreset` in 1: asynchronous, active-low reset.
- `ce` in 1: character clock enable. All counters and outputs advance only on `ce`.
- `cs` in 1: chip select for the CPU port.
- `rs` in 1: register select. 0 selects the address register, 1 selects the data register.
- `wr` in 1: write strobe, sampled on every `clock` when `cs` is high (not gated by `ce`).
- `di` in 8: CPU write data.
- `do` out 8: read data. Returns R12 or R13 when the address register holds 12 or 13. Returns 0x00 otherwise.
- `ma` out MAW: memory address.
- `ra` out RAW: raster address, the scanline within the character row.
- `de` out 1: display enable.
- `hsync` out 1: horizontal sync, active high.
- `vsync` out 1: vertical sync, active high.
- `frame` out 1: one-`ce` pulse at the first character of each frame.

## Operation
- **Register file**
  - `cs&wr&!rs` loads the 5-bit address register from `di[4:0]`.
  - `cs&wr&rs` writes R[addr].
  - Implemented registers: R0 htotal, R1 hdisp, R2 hsyncpos, R3 sync widths (`[3:0]` h, `[7:4]` v), R4 vtotal (rows), R5 vadjust (lines), R6 vdisp (rows), R7 vsyncpos (rows), R9 maxraster, R12/R13 start address (high/low; R12 uses 6 bits).
  - Writes to any other address are ignored.
- **Reset values:** R0=63, R1=32, R2=40, R3=0x35, R4=38, R5=6, R6=32, R7=35, R9=7, R12=R13=0. The address register resets to 0.
- **Counters:** `hc` (8b), `rc` (5b raster), `vc` (7b row), `ac` (5b adjust), `mrow` (MAW, start of current row), `hsc`/`vsc` (4b sync width counters), `inadj` flag.
- **Horizontal**
  - On `ce`, `hc` increments. When `hc==R0`, `hc` returns to 0 and the line ends.
  - If R0 is reprogrammed below the current `hc`, `hc` keeps counting, wraps through 255 to 0, and then resumes normal operation.
- **Line end**
  - If `inadj`: `ac++`. When `ac==R5-1` the frame ends.
  - Else if `rc==R9`: `rc` returns to 0 and `mrow` advances by R1.
    - If `vc==R4`: when R5==0 the frame ends, otherwise `inadj` is set and `ac` is cleared.
    - Otherwise `vc++`.
  - Else: `rc++`.
- **Frame end:** `vc`, `rc`, `ac` and `inadj` clear, and `mrow` is loaded with `{R12,R13}`.
- **Address:** `ma = mrow + hc`, truncated to MAW bits. `ra = rc`. In the adjust region `ra = ac`.
- **Display enable:** `de = (hc<R1) & (vc<R6) & !inadj`.
- **Horizontal sync**
  - Starts when `hc==R2` and lasts R3[3:0] characters. A width of 0 means 16.
  - If the sync would cross `hc` wrap, it continues into the next line.
- **Vertical sync**
  - Starts at line start when `vc==R7` and `rc==0`, and lasts R3[7:4] lines. A width of 0 means 16.
  - A new start while the sync is already active is ignored.
- **Frame pulse:** `frame` is high for the `ce` where `hc==0`, `vc==0`, `rc==0` and `!inadj`.
- **Live compares:** all compares use live register values. A write takes effect on the next `ce`.

## Timing
- On `nreset` low, all counters and outputs go to 0 immediately: `ma=0`, `ra=0`, `de=0`, `hsync=0`, `vsync=0`, `frame=0`, `do=0x00`.
- After `nreset` is released, the first `ce` samples state `hc=0` and frame start.
- **Output latency:** `ma`, `ra`, `de`, `hsync`, `vsync` and `frame` are registered. They show the counter state of the previous `ce`, which is one `ce` of latency, and they are mutually aligned.
- **Read path:** `do` is combinational from the address register and R12/R13.
- **Line and frame length**
  - Line period = R0+1 `ce`.
  - Frame = (R4+1)·(R9+1) + R5 lines.
  - Default: 64 `ce`/line and 318 lines.
- **Simultaneous events:** a CPU write on the same clock as a `ce` is visible to the compare on the following `ce`, not the current one.

## Structure
- **Shared package `crtc_pkg`:**
  - Register index constants R_HTOTAL…R_STARTL.
  - Reset-default constants.
  - Width constants for the counters.
- **Sub-module `crtc_regs`:** the address/data register file, the reset defaults and the read mux.
- **Counters and output registers** stay in `crtc`.

## Test plan
- **Reset defaults:** release reset and run `ce` every clock.
  - `hsync` goes high at output `ce` 41 (hc=40 plus 1 latency) and stays high for 5 `ce`.
  - Line period is 64 and frame period is 64·318 `ce`.
  - `vsync` lasts 3 lines, starting at line 35·8.
- **Display window:** `de` is high for exactly 32 `ce` per line on lines 0–255 and is never high in lines 256–317. `ma` on line 8 starts at 32.
- **Start address:** write R12=0x01, R13=0x80. At the next frame, the first `ma`=0x0180 and `frame` pulses once.
- **Adjust region:** with R5=0, frame = 312 lines. With R5=6, 6 extra lines are produced with `ra`=0..5 and `de`=0.
- **Sync widths of zero:** with R3=0x00, `hsync` lasts 16 `ce` and `vsync` lasts 16 lines.
- **Shrinking R0 and mid-frame reset**
  - Write R0=20 while `hc`=50: `hc` wraps through 255, giving one line of 256 `ce`, then lines of 21 `ce`.
  - Assert `nreset` mid-frame: all outputs are 0 immediately and the registers return to their defaults.
